// File: rtl/philv_imem_loader_if.sv
// Byte-stream input, instruction-memory write port and core-control outputs of the
// Philosophy V boot loader. The master is the stream source and memory side; the slave is the loader.
interface philv_imem_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  imem_wr_en;
    logic [ADDR_WIDTH-1:0] imem_wr_addr;
    logic [31:0]           imem_wr_data;
    logic                  core_rstb;
    logic                  load_done;
    logic                  err;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  imem_wr_en,
        input  imem_wr_addr,
        input  imem_wr_data,
        input  core_rstb,
        input  load_done,
        input  err
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output imem_wr_en,
        output imem_wr_addr,
        output imem_wr_data,
        output core_rstb,
        output load_done,
        output err
    );
endinterface

// File: rtl/philv_imem_loader.sv
// Boot-time loader: assembles a length-prefixed little-endian byte stream into 32-bit
// instruction words, verifies an XOR checksum and only then releases the core from reset.
module philv_imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rstb,
    philv_imem_loader_if.slave  bus
);

    // Word count is 16 bits wide, so compare against capacity with one extra bit.
    localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [7:0]            r_n_lo;
    logic [15:0]           r_n;
    logic [1:0]            r_lane;
    logic [15:0]           r_word_idx;
    logic [31:0]           r_word;
    logic [7:0]            r_xor;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [31:0]           r_wr_data;

    logic        w_ready;
    logic        w_accept;
    logic [15:0] w_n_full;
    logic        w_lane_last;
    logic        w_last_word;
    logic [31:0] w_word_next;

    assign w_ready     = ((r_state == S_LEN0) || (r_state == S_LEN1) ||
                          (r_state == S_DATA) || (r_state == S_CSUM)) && !rstb;
    assign w_accept    = bus.in_valid && w_ready;
    assign w_n_full    = {bus.in_data, r_n_lo};
    assign w_lane_last = (r_lane == 2'd3);
    assign w_last_word = (r_word_idx == (r_n - 16'd1));

    // Incoming byte replaces its lane; the other lanes keep what was already collected.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_word_next[gi*8 +: 8] = (r_lane == 2'(gi)) ? bus.in_data
                                                                : r_word[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            r_state <= S_LEN0;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_LEN0: begin
                if (w_accept) begin
                    w_state_next = S_LEN1;
                end
            end
            S_LEN1: begin
                if (w_accept) begin
                    if (w_n_full == 16'd0) begin
                        w_state_next = S_CSUM;
                    end else if ({1'b0, w_n_full} > CAPACITY) begin
                        w_state_next = S_ERR;
                    end else begin
                        w_state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_accept && w_lane_last && w_last_word) begin
                    w_state_next = S_CSUM;
                end
            end
            S_CSUM: begin
                if (w_accept) begin
                    w_state_next = (bus.in_data == r_xor) ? S_RUN : S_ERR;
                end
            end
            default: begin
                w_state_next = r_state;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            r_n_lo     <= '0;
            r_n        <= '0;
            r_lane     <= '0;
            r_word_idx <= '0;
            r_word     <= '0;
            r_xor      <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    S_LEN0: begin
                        r_n_lo <= bus.in_data;
                    end
                    S_LEN1: begin
                        r_n <= w_n_full;
                    end
                    S_DATA: begin
                        r_word <= w_word_next;
                        r_xor  <= r_xor ^ bus.in_data;
                        r_lane <= r_lane + 2'd1;
                        // Address and data stay put after the pulse until the next word.
                        if (w_lane_last) begin
                            r_wr_en    <= 1'b1;
                            r_wr_addr  <= r_word_idx[ADDR_WIDTH-1:0];
                            r_wr_data  <= w_word_next;
                            r_word_idx <= r_word_idx + 16'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.in_ready     = w_ready;
    assign bus.imem_wr_en   = r_wr_en;
    assign bus.imem_wr_addr = r_wr_addr;
    assign bus.imem_wr_data = r_wr_data;
    assign bus.core_rstb    = (r_state != S_RUN);
    assign bus.load_done    = (r_state == S_RUN);
    assign bus.err          = (r_state == S_ERR);

endmodule

// File: tb/tb_philv_imem_loader.sv
// Directed bench for philv_imem_loader: expected writes are queued as words are sent and
// popped when the write strobe is seen; status outputs are checked after each image.
module tb_philv_imem_loader;

    localparam int AW = 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic clk  = 1'b0;
    logic rstb = 1'b1;

    always #5 clk = ~clk;

    philv_imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

    philv_imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    int          checks    = 0;
    int          failures  = 0;
    wr_t         sb[$];
    logic [31:0] img[$];
    bit          pulse_due = 1'b0;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must match a 4th-byte acceptance and the next queued word.
    always @(negedge clk) begin
        if (bus.imem_wr_en === 1'b1 || pulse_due) begin
            check1("wr_pulse_timing", bus.imem_wr_en, pulse_due);
            if (bus.imem_wr_en === 1'b1) begin
                check1("wr_expected", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    wr_t e;
                    e = sb.pop_front();
                    check32("wr_addr", 32'(bus.imem_wr_addr), 32'(e.addr));
                    check32("wr_data", bus.imem_wr_data, e.data);
                end
                $display("WR addr=%0d data=0x%08h", bus.imem_wr_addr, bus.imem_wr_data);
            end
            pulse_due = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit last_lane, input bit gaps);
        int budget;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        budget = 0;
        while (bus.in_ready !== 1'b1 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 50) begin
            check1("accept_timeout", 1'b0, 1'b1);
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            pulse_due    = last_lane;
        end
    endtask

    task automatic send_image(input int n, input logic [7:0] csum_flip, input bit gaps);
        logic [7:0]  x;
        logic [15:0] nn;
        logic [31:0] w;
        x  = 8'h00;
        nn = 16'(n);
        send_byte(nn[7:0], 1'b0, gaps);
        send_byte(nn[15:8], 1'b0, gaps);
        for (int i = 0; i < n; i++) begin
            w = img[i];
            sb.push_back('{addr: AW'(i), data: w});
            for (int l = 0; l < 4; l++) begin
                x = x ^ w[8*l +: 8];
                send_byte(w[8*l +: 8], l == 3, gaps);
            end
        end
        check1("core_rstb_held", bus.core_rstb, 1'b1);
        send_byte(x ^ csum_flip, 1'b0, gaps);
        $display("IMAGE n=%0d csum=0x%02h sent", n, x ^ csum_flip);
    endtask

    task automatic do_reset();
        rstb         = 1'b1;
        bus.in_valid = 1'b0;
        pulse_due    = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        rstb = 1'b0;
        #1;
        check1("in_ready_after_reset", bus.in_ready, 1'b1);
    endtask

    task automatic check_reset_values(input string tag);
        check1({tag, "_in_ready"},  bus.in_ready,   1'b0);
        check1({tag, "_wr_en"},     bus.imem_wr_en, 1'b0);
        check32({tag, "_wr_addr"},  32'(bus.imem_wr_addr), 32'd0);
        check32({tag, "_wr_data"},  bus.imem_wr_data, 32'd0);
        check1({tag, "_core_rstb"}, bus.core_rstb,  1'b1);
        check1({tag, "_load_done"}, bus.load_done,  1'b0);
        check1({tag, "_err"},       bus.err,        1'b0);
    endtask

    task automatic offer_ignored(input string tag);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5a;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check1(tag, bus.in_ready, 1'b0);
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        #2;
        check_reset_values("por");
        do_reset();

        // Two-word load at full rate.
        img.delete();
        img.push_back(32'h00500113);
        img.push_back(32'h00a00193);
        send_image(2, 8'h00, 1'b0);
        check1("two_core_rstb", bus.core_rstb, 1'b0);
        check1("two_load_done", bus.load_done, 1'b1);
        check1("two_err",       bus.err,       1'b0);
        check1("two_in_ready",  bus.in_ready,  1'b0);
        offer_ignored("run_ignores_bytes");
        check32("two_sb_drained", 32'(sb.size()), 32'd0);
        check32("two_addr_hold", 32'(bus.imem_wr_addr), 32'd1);
        check32("two_data_hold", bus.imem_wr_data, 32'h00a00193);

        // Empty image.
        do_reset();
        img.delete();
        send_image(0, 8'h00, 1'b0);
        check1("empty_load_done", bus.load_done, 1'b1);
        check1("empty_core_rstb", bus.core_rstb, 1'b0);
        check1("empty_no_write",  bus.imem_wr_en, 1'b0);

        // Bad checksum.
        do_reset();
        img.delete();
        img.push_back(32'h00500113);
        img.push_back(32'h00a00193);
        send_image(2, 8'h01, 1'b0);
        check1("bad_err",       bus.err,       1'b1);
        check1("bad_core_rstb", bus.core_rstb, 1'b1);
        check1("bad_load_done", bus.load_done, 1'b0);
        check1("bad_in_ready",  bus.in_ready,  1'b0);
        offer_ignored("err_ignores_bytes");
        check32("bad_sb_drained", 32'(sb.size()), 32'd0);

        // Oversize word count.
        do_reset();
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h01, 1'b0, 1'b0);
        check1("over_err",      bus.err,      1'b1);
        check1("over_in_ready", bus.in_ready, 1'b0);
        repeat (4) @(negedge clk);
        check1("over_no_write", bus.imem_wr_en, 1'b0);
        check1("over_err_sticky", bus.err, 1'b1);

        // Full capacity with random valid gaps.
        do_reset();
        img.delete();
        for (int i = 0; i < 256; i++) begin
            img.push_back($urandom());
        end
        send_image(256, 8'h00, 1'b1);
        check1("full_load_done", bus.load_done, 1'b1);
        check1("full_err",       bus.err,       1'b0);
        @(negedge clk);
        check32("full_sb_drained", 32'(sb.size()), 32'd0);
        check32("full_last_addr",  32'(bus.imem_wr_addr), 32'd255);
        check32("full_last_data",  bus.imem_wr_data, img[255]);

        // Reset in the middle of a load, then a fresh one-word image.
        do_reset();
        img.delete();
        img.push_back($urandom());
        img.push_back($urandom());
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        sb.push_back('{addr: AW'(0), data: img[0]});
        for (int l = 0; l < 4; l++) begin
            send_byte(img[0][8*l +: 8], l == 3, 1'b0);
        end
        send_byte(img[1][7:0], 1'b0, 1'b0);
        check1("mid_core_rstb_before", bus.core_rstb, 1'b1);
        #2;
        rstb = 1'b1;
        #1;
        check_reset_values("mid");
        do_reset();
        img.delete();
        img.push_back(32'h00000013 | ($urandom() & 32'hfff00000));
        send_image(1, 8'h00, 1'b0);
        check1("mid_load_done", bus.load_done, 1'b1);
        check1("mid_core_rstb", bus.core_rstb, 1'b0);
        @(negedge clk);
        check32("mid_sb_drained", 32'(sb.size()), 32'd0);
        check32("mid_addr", 32'(bus.imem_wr_addr), 32'd0);
        check32("mid_data", bus.imem_wr_data, img[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/philv_imem_loader.md
# philv_imem_loader

Boot-time instruction-memory loader for the Philosophy V core. It accepts a byte stream carrying a program image and assembles the bytes into 32-bit little-endian words. Each word is written into the core's instruction memory through a write port. The core is held in reset until the whole image is loaded and the checksum matches, and only then released. The block sits directly upstream of `philosophyVCore`: it feeds the core's instruction memory and drives the core's reset input.

## Interface
Parameters:
- `ADDR_WIDTH`, 8 — instruction-memory word-address width; capacity is 2^ADDR_WIDTH words.

Ports:
- `clk`  in  1  — single clock; all logic is rising-edge.
- `rstb`  in  1  — reset, asynchronous and active-high.
- `in_valid`  in  1  — a byte is offered on `in_data`.
- `in_data`  in  8  — stream byte.
- `in_ready`  out  1  — the loader can accept a byte this cycle.
- `imem_wr_en`  out  1  — instruction-memory write strobe, one-cycle pulse.
- `imem_wr_addr`  out  ADDR_WIDTH  — word address of the write.
- `imem_wr_data`  out  32  — assembled instruction word.
- `core_rstb`  out  1  — active-high reset to the core; held at 1 until the load succeeds.
- `load_done`  out  1  — the image is loaded and verified; the core is running.
- `err`  out  1  — the load failed; sticky until `rstb`.

## Operation
- Stream format, in order:
  - N_LO, N_HI: 16-bit word count N, little-endian.
  - N×4 payload bytes: each word is sent LSB first.
  - CSUM: one byte, equal to the XOR of all payload bytes.
- Handshake: a byte is accepted on a rising edge where `in_valid && in_ready`. `in_ready` is combinational from state: it is 1 in LEN0, LEN1, DATA and CSUM, and 0 otherwise.
- States:
  - LEN0 → LEN1 on an accepted byte; the byte goes to N[7:0].
  - LEN1 → DATA on an accepted byte; the byte goes to N[15:8]. The following exceptions apply in place of DATA:
    - If N == 0, go to CSUM; the expected checksum is 0x00.
    - If N > 2^ADDR_WIDTH, go to ERR and do no writes.
  - DATA: the byte lane counter runs 0..3 and each byte is shifted into the word register at lane×8. The running XOR is updated on every payload byte.
    - On the 4th lane, the word is issued (see Timing) and the word index increments.
    - After word N−1 is issued, go to CSUM.
  - CSUM → RUN if the accepted byte equals the running XOR; otherwise → ERR.
  - RUN: terminal. `core_rstb`=0, `load_done`=1, `in_ready`=0.
  - ERR: terminal. `core_rstb`=1, `err`=1, `in_ready`=0.
- Word index: 0..N−1, written to `imem_wr_addr`. N == 2^ADDR_WIDTH is legal and fills memory exactly. The index never wraps into already-written words.
- `in_valid` gaps are allowed anywhere; the state is held while no byte is accepted.
- Bytes offered in RUN or ERR are ignored and never acknowledged.
- Words outside 0..N−1 are not written.

## Timing
- Reset values, asserted asynchronously while `rstb`=1:
  - state=LEN0, `in_ready`=0.
  - `imem_wr_en`=0, `imem_wr_addr`=0, `imem_wr_data`=0.
  - `core_rstb`=1, `load_done`=0, `err`=0.
  - Counters and XOR are cleared.
- `in_ready` becomes 1 in the first cycle after `rstb` deasserts.
- Write latency: if the 4th byte of a word is accepted at edge k, then `imem_wr_en`=1 for exactly the cycle between edges k and k+1, with `imem_wr_addr`/`imem_wr_data` valid at the same time. Address and data hold their values after the pulse.
- Back-to-back words at full rate give one write every 4 cycles. There is no stall path, because the memory write always succeeds.
- The CSUM byte may be accepted in the same cycle as the last word's write pulse.
- Release: `core_rstb` falls and `load_done` rises at the edge after the CSUM byte is accepted. That is at least one cycle after the last write, so the core's first fetch sees the full image.
- Reset mid-load: everything returns to the reset values immediately. Memory contents already written are not cleared. A new stream must start again from N_LO.

## Test plan
- Two-word load. Stream 02 00, 13 01 50 00, 93 01 a0 00, CSUM = XOR of the 8 payload bytes.
  - Required: wr pulse at addr 0 with 0x00500113, then addr 1 with 0x00a00193.
  - Then `core_rstb` 1→0 and `load_done`=1 one edge after CSUM.
- Empty image. Stream 00 00 00.
  - Required: no `imem_wr_en`; RUN after the CSUM edge.
- Bad checksum. The two-word stream with CSUM xor 0x01.
  - Required: both writes still occur; `err`=1, `core_rstb` stays 1, `in_ready`=0 after that.
- Oversize. With ADDR_WIDTH=8, stream 01 01 (N=257).
  - Required: ERR after the N_HI edge; zero writes.
- Full capacity and gaps. N=256 with random `in_valid` gaps.
  - Required: 256 writes at addr 0..255 with the correct words; a write pulse never coincides with a non-4th-byte edge.
- Reset mid-load. Assert `rstb` after 5 payload bytes.
  - Required: outputs return to reset values at once; a fresh one-word load then writes addr 0 correctly and releases the core.
